// File: rtl/sha256_round_ctrl_if.sv
// Message-word stream and digest bus between the padder, the SHA-256
// round controller and the digest consumer.
interface sha256_round_ctrl_if;
  logic         start;
  logic         first_blk;
  logic         w_valid;
  logic [31:0]  w_data;
  logic         w_ready;
  logic         busy;
  logic         done;
  logic [255:0] digest;

  // Upstream side: padder/host issuing blocks and words.
  modport master (
    output start, first_blk, w_valid, w_data,
    input  w_ready, busy, done, digest
  );

  // Controller side.
  modport slave (
    input  start, first_blk, w_valid, w_data,
    output w_ready, busy, done, digest
  );
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: accepts sixteen message words, runs 64
// rounds at one round per cycle, then folds the working variables into the
// chaining value and publishes the digest.
module sha256_round_ctrl (
  input  logic               clk,
  input  logic               rst,
  sha256_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  // Eight 32-bit words, index 0 (H0 / A) in the most significant slot.
  typedef logic [0:7][31:0] octet_t;

  localparam octet_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sml_sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t       state_q, state_d;
  logic [5:0]   t_q;
  octet_t       wv_q;       // working variables A..H
  octet_t       chain_q;    // chaining value latched at start
  octet_t       digest_q;
  logic [31:0]  win_q [16]; // W(t-16) in slot 0 .. W(t-1) in slot 15
  logic         done_q;

  logic         load;
  logic         round_en;
  logic         w_ready_c;
  logic [31:0]  wt, t1, t2;

  // State register; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers update from values sampled before the edge.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; w_ready depends only on registered state and t.
  always_comb begin
    // NOTE: all outputs of this block get a default first, so no path can
    // leave them unassigned and infer a latch.
    state_d   = state_q;
    load      = 1'b0;
    round_en  = 1'b0;
    w_ready_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (t_q < 6'd16) begin
          w_ready_c = 1'b1;
          round_en  = bus.w_valid;
        end else begin
          round_en  = 1'b1;
        end
        if (round_en && t_q == 6'd63) state_d = FINAL;
      end
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Round datapath: message word select, schedule expansion and T1/T2.
  always_comb begin
    wt = bus.w_data;
    if (t_q >= 6'd16)
      wt = sml_sig1(win_q[14]) + win_q[9] + sml_sig0(win_q[1]) + win_q[0];
    t1 = wv_q[7] + big_sig1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6]) + K[t_q] + wt;
    t2 = big_sig0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);
  end

  // Working variables, schedule window, round counter, digest and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q      <= '0;
      wv_q     <= '0;
      chain_q  <= IV;
      digest_q <= IV;
      done_q   <= 1'b0;
      // NOTE: the schedule window is a small register file, not a RAM, so it
      // is cleared explicitly here to give a known state after reset.
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      done_q <= (state_q == FINAL);
      if (load) begin
        t_q     <= '0;
        wv_q    <= bus.first_blk ? IV : digest_q;
        chain_q <= bus.first_blk ? IV : digest_q;
      end else if (round_en) begin
        t_q  <= t_q + 6'd1;
        wv_q <= {t1 + t2, wv_q[0], wv_q[1], wv_q[2],
                 wv_q[3] + t1, wv_q[4], wv_q[5], wv_q[6]};
        for (int i = 0; i < 15; i++) win_q[i] <= win_q[i + 1];
        win_q[15] <= wt;
      end
      if (state_q == FINAL) begin
        for (int i = 0; i < 8; i++) digest_q[i] <= chain_q[i] + wv_q[i];
      end
    end
  end

  assign bus.w_ready = w_ready_c;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.digest  = digest_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: known FIPS vectors, control
// corners and random blocks against a straightforward SHA-256 model.
module tb_sha256_round_ctrl;

  typedef logic [31:0] blk_t [16];
  typedef int          stall_t [16];

  localparam logic [255:0] IV_D   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPT_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_D  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [255:0] model_digest;

  // Digest-stability monitor for the two-block chain.
  logic         track = 1'b0;
  logic [255:0] track_val;
  int           move_count = 0;

  sha256_round_ctrl_if bus ();

  sha256_round_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (track && bus.digest !== track_val) move_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] chain, input blk_t m);
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2, chv, mj;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) h[i] = chain[255 - 32*i -: 32];
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = h[i];
    for (int i = 0; i < 64; i++) begin
      s1  = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
      chv = (v[4] & v[5]) ^ (~v[4] & v[6]);
      t1  = v[7] + s1 + chv + KT[i] + w[i];
      s0  = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
      mj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t2  = s0 + mj;
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[i] + v[i];
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pulses start and feeds the sixteen words, with stalls[i] idle cycles
  // before word i. Returns the cycle number of the start edge.
  task automatic begin_block(input logic first, input blk_t words,
                             input stall_t stalls, output int start_cyc);
    int guard;
    bus.first_blk = first;
    bus.start     = 1'b1;
    step();
    start_cyc = cyc;
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.w_valid = 1'b0;
      bus.w_data  = $urandom;
      repeat (stalls[i]) step();
      bus.w_valid = 1'b1;
      bus.w_data  = words[i];
      guard = 0;
      while (!bus.w_ready && guard < 8) begin
        step();
        guard++;
      end
      step();
    end
    bus.w_valid = 1'b0;
    bus.w_data  = $urandom;
  endtask

  // Waits (bounded) for done; optionally pulses start at a given edge count.
  task automatic wait_done(input int start_cyc, input int start_at,
                           output int done_edge, output logic wr_bad);
    done_edge = -1;
    wr_bad    = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.done) begin
        done_edge = cyc - start_cyc;
        break;
      end
      if (bus.w_ready) wr_bad = 1'b1;
      if (start_at >= 0 && cyc - start_cyc == start_at) begin
        bus.start     = 1'b1;
        bus.first_blk = 1'b1;
      end
      step();
      bus.start = 1'b0;
    end
  endtask

  function automatic blk_t abc_blk();
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = 32'h0;
    b[0]  = 32'h61626380;
    b[15] = 32'h00000018;
    return b;
  endfunction

  function automatic stall_t no_stall();
    stall_t s;
    for (int i = 0; i < 16; i++) s[i] = 0;
    return s;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.first_blk = 1'b0; bus.w_valid = 1'b0; bus.w_data = '0;
    step(); step();
    rst = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.w_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl: busy=%b done=%b w_ready=%b, want 0 0 0", bus.busy, bus.done, bus.w_ready);
    end
    tests_run++;
    if (bus.digest !== IV_D) begin
      tests_failed++;
      $display("FAIL reset_digest: got %h want %h", bus.digest, IV_D);
    end
    model_digest = IV_D;
  endtask

  task automatic test_abc();
    int sc, de; logic wb;
    begin_block(1'b1, abc_blk(), no_stall(), sc);
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL abc_busy: got %b want 1", bus.busy);
    end
    wait_done(sc, -1, de, wb);
    tests_run++;
    if (de !== 65) begin
      tests_failed++;
      $display("FAIL abc_latency: done at edge %0d want 65", de);
    end
    tests_run++;
    if (bus.digest !== ABC_D) begin
      tests_failed++;
      $display("FAIL abc_digest: got %h want %h", bus.digest, ABC_D);
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abc_busy_fall: got %b want 0 in done cycle", bus.busy);
    end
    step();
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abc_done_pulse: done=%b one cycle later, want 0", bus.done);
    end
    model_digest = ABC_D;
  endtask

  task automatic test_empty();
    int sc, de; logic wb; blk_t b;
    for (int i = 0; i < 16; i++) b[i] = 32'h0;
    b[0] = 32'h80000000;
    begin_block(1'b1, b, no_stall(), sc);
    wait_done(sc, -1, de, wb);
    tests_run++;
    if (bus.digest !== EMPT_D || de !== 65) begin
      tests_failed++;
      $display("FAIL empty_digest: got %h at edge %0d want %h at 65", bus.digest, de, EMPT_D);
    end
    model_digest = EMPT_D;
    step();
  endtask

  task automatic test_two_block();
    int sc, de, mc; logic wb; blk_t b1, b2; logic [255:0] exp1;
    b1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
           32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
           32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
           32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    for (int i = 0; i < 16; i++) b2[i] = 32'h0;
    b2[15] = 32'h000001c0;
    exp1 = ref_compress(IV_D, b1);
    begin_block(1'b1, b1, no_stall(), sc);
    wait_done(sc, -1, de, wb);
    tests_run++;
    if (bus.digest !== exp1) begin
      tests_failed++;
      $display("FAIL two_blk1: got %h want %h", bus.digest, exp1);
    end
    track_val = exp1;
    mc = move_count;
    track = 1'b1;
    begin_block(1'b0, b2, no_stall(), sc);
    wait_done(sc, -1, de, wb);
    track = 1'b0;
    tests_run++;
    if (move_count !== mc) begin
      tests_failed++;
      $display("FAIL two_blk_stable: digest moved %0d times between done pulses, want 0", move_count - mc);
    end
    tests_run++;
    if (bus.digest !== TWO_D || de !== 65) begin
      tests_failed++;
      $display("FAIL two_blk_final: got %h at edge %0d want %h at 65", bus.digest, de, TWO_D);
    end
    model_digest = TWO_D;
    step();
  endtask

  task automatic test_stalls();
    int sc, de; logic wb; stall_t s;
    s = no_stall();
    s[0] = 3;
    s[9] = 2;
    begin_block(1'b1, abc_blk(), s, sc);
    wait_done(sc, -1, de, wb);
    tests_run++;
    if (de !== 70) begin
      tests_failed++;
      $display("FAIL stall_latency: done at edge %0d want 70", de);
    end
    tests_run++;
    if (bus.digest !== ABC_D) begin
      tests_failed++;
      $display("FAIL stall_digest: got %h want %h", bus.digest, ABC_D);
    end
    tests_run++;
    if (wb !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_wready: w_ready seen %b after t=16, want 0", wb);
    end
    model_digest = ABC_D;
    step();
  endtask

  task automatic test_start_ignored();
    int sc, de; logic wb;
    begin_block(1'b1, abc_blk(), no_stall(), sc);
    wait_done(sc, 30, de, wb);
    tests_run++;
    if (bus.digest !== ABC_D || de !== 65) begin
      tests_failed++;
      $display("FAIL start_ignored: got %h at edge %0d want %h at 65", bus.digest, de, ABC_D);
    end
    model_digest = ABC_D;
    step();
  endtask

  task automatic test_rst_midblock();
    int sc, de, guard; logic wb, saw_done;
    begin_block(1'b0, abc_blk(), no_stall(), sc);
    guard = 0;
    while (cyc - sc < 40 && guard < 100) begin
      step();
      guard++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.w_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_ctl: busy=%b w_ready=%b want 0 0", bus.busy, bus.w_ready);
    end
    tests_run++;
    if (bus.digest !== IV_D) begin
      tests_failed++;
      $display("FAIL rst_mid_digest: got %h want %h", bus.digest, IV_D);
    end
    saw_done = 1'b0;
    repeat (80) begin
      if (bus.done) saw_done = 1'b1;
      step();
    end
    tests_run++;
    if (saw_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_done: done seen=%b after abort, want 0", saw_done);
    end
    begin_block(1'b1, abc_blk(), no_stall(), sc);
    wait_done(sc, -1, de, wb);
    tests_run++;
    if (bus.digest !== ABC_D || de !== 65) begin
      tests_failed++;
      $display("FAIL rst_mid_after: got %h at edge %0d want %h at 65", bus.digest, de, ABC_D);
    end
    model_digest = ABC_D;
    step();
  endtask

  task automatic test_rst_with_start();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.first_blk = 1'b1;
    step();
    rst = 1'b0;
    bus.start = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_start_now: busy=%b want 0", bus.busy);
    end
    step();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.w_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_start_idle: busy=%b w_ready=%b want 0 0", bus.busy, bus.w_ready);
    end
    model_digest = IV_D;
  endtask

  task automatic test_back_to_back();
    int sc, de, d1; logic wb; blk_t a, b; logic [255:0] ea, eb;
    for (int i = 0; i < 16; i++) begin
      a[i] = $urandom;
      b[i] = $urandom;
    end
    ea = ref_compress(IV_D, a);
    eb = ref_compress(ea, b);
    begin_block(1'b1, a, no_stall(), sc);
    wait_done(sc, -1, de, wb);
    d1 = cyc;
    tests_run++;
    if (bus.digest !== ea) begin
      tests_failed++;
      $display("FAIL b2b_first: got %h want %h", bus.digest, ea);
    end
    begin_block(1'b0, b, no_stall(), sc);
    wait_done(sc, -1, de, wb);
    tests_run++;
    if (cyc - d1 !== 66) begin
      tests_failed++;
      $display("FAIL b2b_spacing: %0d cycles between done pulses want 66", cyc - d1);
    end
    tests_run++;
    if (bus.digest !== eb) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h want %h", bus.digest, eb);
    end
    model_digest = eb;
    step();
  endtask

  task automatic test_random();
    int sc, de, total; logic wb, first; blk_t m; stall_t s; logic [255:0] exp;
    for (int n = 0; n < 6; n++) begin
      first = 1'($urandom_range(0, 1));
      total = 0;
      for (int i = 0; i < 16; i++) begin
        m[i] = $urandom;
        s[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        total += s[i];
      end
      exp = ref_compress(first ? IV_D : model_digest, m);
      begin_block(first, m, s, sc);
      wait_done(sc, -1, de, wb);
      tests_run++;
      if (bus.digest !== exp || de !== 65 + total) begin
        tests_failed++;
        $display("FAIL random_%0d: got %h at edge %0d want %h at %0d", n, bus.digest, de, exp, 65 + total);
      end
      model_digest = exp;
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_abc();
    test_empty();
    test_two_block();
    test_stalls();
    test_start_ignored();
    test_rst_midblock();
    test_rst_with_start();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
